// File: rtl/alu_unit_if.sv
// Dispatch/result bus between the reservation station and the ALU execution stage.
interface alu_unit_if #(
   parameter int unsigned ROB_BIT = 5
);
   logic [6:0]         alu_op;
   logic [31:0]        Vi;
   logic [31:0]        Vj;
   logic [31:0]        imm;
   logic [ROB_BIT-1:0] rd;
   logic [31:0]        pc;
   logic               alu_busy;
   logic               rs_ready;
   logic [ROB_BIT-1:0] rs_ROB_id;
   logic [31:0]        rs_val;
   logic               br_valid;
   logic               br_taken;
   logic [31:0]        br_target;

   modport master (
      output alu_op, Vi, Vj, imm, rd, pc,
      input  alu_busy, rs_ready, rs_ROB_id, rs_val, br_valid, br_taken, br_target
   );

   modport slave (
      input  alu_op, Vi, Vj, imm, rd, pc,
      output alu_busy, rs_ready, rs_ROB_id, rs_val, br_valid, br_taken, br_target
   );
endinterface

// File: rtl/alu_unit.sv
// Integer/branch/jump execution stage with a registered result broadcast.
// Optional iterative 32-cycle multiplier enabled by defining ALU_MUL_EN.
module alu_unit #(
   parameter int unsigned ROB_BIT = 5
) (
   input  logic     clk_in,
   input  logic     rst_in,
   input  logic     rdy_in,
   input  logic     clear_flag,
   alu_unit_if.slave bus
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned PW    = 2 * XLEN;
   localparam int unsigned CNT_W = 5;
   localparam logic [2:0] CLS_OP     = 3'd1;
   localparam logic [2:0] CLS_OPIMM  = 3'd2;
   localparam logic [2:0] CLS_BRANCH = 3'd3;
   localparam logic [2:0] CLS_UPPER  = 3'd4;
   localparam logic [2:0] CLS_MULDIV = 3'd5;
   localparam logic [2:0] CLS_JAL    = 3'd6;
   localparam logic [2:0] CLS_JALR   = 3'd7;

   logic [2:0] cls;
   logic [2:0] f3;
   logic       alt;
   assign cls = bus.alu_op[2:0];
   assign f3  = bus.alu_op[5:3];
   assign alt = bus.alu_op[6];

   logic               rs_ready_q, rs_ready_d;
   logic [ROB_BIT-1:0] rs_rob_id_q, rs_rob_id_d;
   logic [XLEN-1:0]    rs_val_q, rs_val_d;
   logic               br_valid_q, br_valid_d;
   logic               br_taken_q, br_taken_d;
   logic [XLEN-1:0]    br_target_q, br_target_d;

   logic [XLEN-1:0] op2, res, target;
   logic [4:0]      shamt;
   logic            is_br, taken;

   // Single-cycle result for the op currently on the bus
   always_comb begin
      op2    = (cls == CLS_OPIMM) ? bus.imm : bus.Vj;
      shamt  = op2[4:0];
      res    = '0;
      target = '0;
      is_br  = 1'b0;
      taken  = 1'b0;
      case (cls)
         CLS_OP, CLS_OPIMM: begin
            case (f3)
               3'b000:  res = (alt && cls == CLS_OP) ? bus.Vi - op2 : bus.Vi + op2;
               3'b001:  res = bus.Vi << shamt;
               3'b010:  res = XLEN'($signed(bus.Vi) < $signed(op2));
               3'b011:  res = XLEN'(bus.Vi < op2);
               3'b100:  res = bus.Vi ^ op2;
               3'b101:  res = alt ? XLEN'($signed(bus.Vi) >>> shamt) : bus.Vi >> shamt;
               3'b110:  res = bus.Vi | op2;
               default: res = bus.Vi & op2;
            endcase
         end
         CLS_BRANCH: begin
            is_br  = 1'b1;
            target = bus.pc + bus.imm;
            case (f3)
               3'b000:  taken = (bus.Vi == bus.Vj);
               3'b001:  taken = (bus.Vi != bus.Vj);
               3'b100:  taken = ($signed(bus.Vi) < $signed(bus.Vj));
               3'b101:  taken = ($signed(bus.Vi) >= $signed(bus.Vj));
               3'b110:  taken = (bus.Vi < bus.Vj);
               3'b111:  taken = (bus.Vi >= bus.Vj);
               default: taken = 1'b0;
            endcase
            res = XLEN'(taken);
         end
         CLS_UPPER: res = (f3[0] ? bus.pc : '0) + bus.imm;
         CLS_JAL: begin
            is_br  = 1'b1;
            taken  = 1'b1;
            res    = bus.pc + XLEN'(4);
            target = bus.pc + bus.imm;
         end
         CLS_JALR: begin
            is_br  = 1'b1;
            taken  = 1'b1;
            res    = bus.pc + XLEN'(4);
            target = (bus.Vi + bus.imm) & ~XLEN'(1);
         end
         default: ;
      endcase
   end

`ifdef ALU_MUL_EN
   typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_e;
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]      mcand_q, mcand_d, prod_q, prod_d, prod_sum, prod_fix;
   logic [XLEN-1:0]    mplr_q, mplr_d, abs_a, abs_b;
   logic               neg_q, neg_d, hi_q, hi_d, sgn_a, sgn_b;
   logic [ROB_BIT-1:0] tag_q, tag_d;

   assign bus.alu_busy = (state_q == MUL);
`else
   assign bus.alu_busy = 1'b0;
`endif

   // Next-state: clear beats everything, rdy_in low freezes everything
   always_comb begin
      rs_ready_d  = rs_ready_q;
      rs_rob_id_d = rs_rob_id_q;
      rs_val_d    = rs_val_q;
      br_valid_d  = br_valid_q;
      br_taken_d  = br_taken_q;
      br_target_d = br_target_q;
`ifdef ALU_MUL_EN
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      prod_d   = prod_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      tag_d    = tag_q;
      prod_sum = prod_q + (mplr_q[0] ? mcand_q : PW'(0));
      prod_fix = neg_q ? (~prod_sum + PW'(1)) : prod_sum;
      sgn_a    = (f3[1:0] != 2'b11);
      sgn_b    = ~f3[1];
      abs_a    = (sgn_a && bus.Vi[XLEN-1]) ? (~bus.Vi + XLEN'(1)) : bus.Vi;
      abs_b    = (sgn_b && bus.Vj[XLEN-1]) ? (~bus.Vj + XLEN'(1)) : bus.Vj;
`endif
      if (rdy_in) begin
         rs_ready_d  = 1'b0;
         rs_rob_id_d = '0;
         rs_val_d    = '0;
         br_valid_d  = 1'b0;
         br_taken_d  = 1'b0;
         br_target_d = '0;
         if (clear_flag) begin
`ifdef ALU_MUL_EN
            state_d = IDLE;
            cnt_d   = '0;
`endif
         end
`ifdef ALU_MUL_EN
         else if (state_q == MUL) begin
            prod_d  = prod_sum;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(31)) begin
               state_d     = IDLE;
               cnt_d       = '0;
               rs_ready_d  = 1'b1;
               rs_rob_id_d = tag_q;
               rs_val_d    = hi_q ? prod_fix[PW-1:XLEN] : prod_fix[XLEN-1:0];
            end
         end else if (cls == CLS_MULDIV) begin
            state_d = MUL;
            cnt_d   = '0;
            prod_d  = '0;
            mcand_d = PW'(abs_a);
            mplr_d  = abs_b;
            neg_d   = (sgn_a & bus.Vi[XLEN-1]) ^ (sgn_b & bus.Vj[XLEN-1]);
            hi_d    = (f3[1:0] != 2'b00);
            tag_d   = bus.rd;
         end
`endif
         else if (bus.alu_op != '0) begin
            rs_ready_d  = 1'b1;
            rs_rob_id_d = bus.rd;
            rs_val_d    = res;
            br_valid_d  = is_br;
            br_taken_d  = taken;
            br_target_d = target;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         rs_ready_q  <= 1'b0;
         rs_rob_id_q <= '0;
         rs_val_q    <= '0;
         br_valid_q  <= 1'b0;
         br_taken_q  <= 1'b0;
         br_target_q <= '0;
`ifdef ALU_MUL_EN
         state_q <= IDLE;
         cnt_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         prod_q  <= '0;
         neg_q   <= 1'b0;
         hi_q    <= 1'b0;
         tag_q   <= '0;
`endif
      end else begin
         rs_ready_q  <= rs_ready_d;
         rs_rob_id_q <= rs_rob_id_d;
         rs_val_q    <= rs_val_d;
         br_valid_q  <= br_valid_d;
         br_taken_q  <= br_taken_d;
         br_target_q <= br_target_d;
`ifdef ALU_MUL_EN
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         prod_q  <= prod_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         tag_q   <= tag_d;
`endif
      end
   end

   assign bus.rs_ready  = rs_ready_q;
   assign bus.rs_ROB_id = rs_rob_id_q;
   assign bus.rs_val    = rs_val_q;
   assign bus.br_valid  = br_valid_q;
   assign bus.br_taken  = br_taken_q;
   assign bus.br_target = br_target_q;
endmodule

// File: doc/alu_unit.md
# alu_unit

Execution stage directly downstream of the reservation station. It takes one dispatched micro-op per cycle (`alu_op`, operands, immediate, pc, ROB tag), computes integer, branch and jump results, and broadcasts a registered result to the ROB, RS and LSB on the `rs_*` bus. When `ALU_MUL_EN` is compiled in, it also provides an iterative 32-cycle multiplier that stalls dispatch through `alu_busy`.

## Interface
- Parameters:
- `ROB_BIT`, default 5: ROB tag width.
- Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  asynchronous, active-low reset.
- `rdy_in`  in  1  global enable; when low, all state and outputs hold.
- `clear_flag`  in  1  synchronous flush on misprediction.
- `alu_op`  in  7  micro-op; all-zero means bubble.
- `Vi`, `Vj`  in  32  source operand values.
- `imm`  in  32  sign-extended immediate.
- `rd`  in  ROB_BIT  destination ROB tag.
- `pc`  in  32  instruction address.
- `alu_busy`  out  1  high while a multiply is in flight; RS must not dispatch.
- `rs_ready`  out  1  result valid (one-cycle pulse).
- `rs_ROB_id`  out  ROB_BIT  tag of the result.
- `rs_val`  out  32  result value.
- `br_valid`  out  1  result belongs to a branch or jump.
- `br_taken`  out  1  branch taken (always 1 for jumps).
- `br_target`  out  32  resolved target address.

## Operation
- `alu_op` encoding:
  - [6] = alt (SUB, SRA, SRAI).
  - [5:3] = RISC-V funct3.
  - [2:0] = class: 0 NOP, 1 OP, 2 OP-IMM, 3 BRANCH, 4 UPPER, 5 MULDIV, 6 JAL, 7 JALR.
- Operand 2 selection: `Vj` for classes 1 and 3; `imm` for class 2.
- Shift amount is operand2[4:0].
- alt is honoured only for funct3 000 in class 1 and funct3 101 in classes 1/2; otherwise it is ignored.
- Per-class results:
  - OP / OP-IMM: ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND per funct3. Arithmetic is modulo 2^32.
  - BRANCH: BEQ/BNE/BLT/BGE/BLTU/BGEU per funct3. `rs_val` = taken (0/1); `br_target` = pc+imm.
  - UPPER: `rs_val` = (funct3[0] ? pc : 0) + imm. This covers AUIPC and LUI.
  - JAL: `rs_val` = pc+4; target = pc+imm.
  - JALR: `rs_val` = pc+4; target = (Vi+imm) & ~1.
  - For both JAL and JALR, `br_taken` = 1.
- `br_valid` = 1 only for classes 3, 6 and 7. `br_taken` and `br_target` are 0 otherwise.
- FSM states:
  - IDLE: a nonzero op is registered into the outputs on the next edge. A class-5 op (with the feature enabled) moves to MUL.
  - MUL: 32 shift-add iterations on |Vi|, |Vj| (sign handling per funct3: MUL, MULH, MULHSU, MULHU). The ROB tag is latched. After the last iteration the product is sign-corrected and `rs_val` is set to the low or high word. Then return to IDLE.
- A bubble in IDLE drives `rs_ready` to 0 and all result outputs to 0.
- Input ops presented while in MUL are ignored.

## Timing
- Reset (`rst_in` = 0, asynchronous): state IDLE; `rs_ready`, `rs_ROB_id`, `rs_val`, `br_valid`, `br_taken`, `br_target` = 0; `alu_busy` = 0; counter = 0.
- Single-cycle ops: sampled at edge E, outputs valid during the cycle after E. `rs_ready` is a one-cycle pulse; back-to-back ops give back-to-back pulses.
- Multiply: sampled at E0; iterations occur at E1..E32; the result is registered at E32.
- `alu_busy` = (state == MUL), combinational from state. It is high in the cycles after E0 up to edge E32 and low after E32. The next op can be sampled at E33.
- `clear_flag` (with `rdy_in` high): takes priority over everything. State goes to IDLE, all outputs go to 0, and the op on the inputs that cycle is discarded.
- `rdy_in` low: no state change, even with `clear_flag` asserted. A multiply in progress pauses and resumes without loss.

## Configuration
- `ALU_MUL_EN` defined: MUL state, counter and product datapath are compiled in.
- `ALU_MUL_EN` undefined: no MUL state and `alu_busy` is tied to 0. A class-5 op completes in a single cycle with `rs_val` = 0 and `rs_ready` = 1, so the ROB never hangs.

## Test plan
- OP SUB (alt=1, funct3 000), Vi=5, Vj=7, rd=3 → next cycle `rs_ready`=1, `rs_ROB_id`=3, `rs_val`=0xFFFFFFFE, `br_valid`=0.
- BLT, Vi=0xFFFFFFFF, Vj=1, pc=0x100, imm=0x20 → `br_valid`=1, `br_taken`=1, `br_target`=0x120, `rs_val`=1. The same operands with BLTU give `br_taken`=0.
- JALR, Vi=0x1003, imm=4, pc=0x40 → `br_target`=0x1006, `rs_val`=0x44, `br_taken`=1.
- (`ALU_MUL_EN`) MULH, Vi=0xFFFFFFFE, Vj=3, rd=9 → `alu_busy` high for 32 cycles, ops issued meanwhile are ignored, then `rs_val`=0xFFFFFFFF with `rs_ROB_id`=9. MUL on the same operands gives 0xFFFFFFFA.
- `clear_flag` asserted 10 cycles into a multiply → next cycle `alu_busy`=0, `rs_ready`=0, and no late result pulse ever appears.
- Reset asserted mid-ADD with `rdy_in` toggling → outputs are 0 immediately; with `rdy_in` low, the outputs hold their last values across 3 cycles.
